vram_arbiter: RTL and testbench

//  Shares the single external VRAM port between the video fetch engine and the Z80.

---
 rtl/vram_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Arbitrates the single external VRAM port between video char-cell fetches (strict priority)
// and Z80 byte accesses; one registered request to the memory controller at a time.
module vram_arbiter #(
  parameter int AW = 19,
  parameter int DW = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr1,
  input  logic [AW-1:0] vid_addr2,
  output logic [DW-1:0] vid_dout1,
  output logic [DW-1:0] vid_dout2,
  output logic          vid_valid,
  output logic          vid_late,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_busy,
  output logic          cpu_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-2:0] mem_addr,
  output logic [1:0]    mem_be,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_V1, S_V2, S_CPU} state_t;

  function automatic logic [1:0] cpu_be(input logic we, input logic lsb);
    return we ? (lsb ? 2'b10 : 2'b01) : 2'b11;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [DW-1:0] w, input logic lsb);
    return lsb ? w[15:8] : w[7:0];
  endfunction

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-2:0] mem_addr_q, mem_addr_d;
  logic [1:0]    mem_be_q, mem_be_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic [DW-1:0] vid_dout1_q, vid_dout1_d;
  logic [DW-1:0] vid_dout2_q, vid_dout2_d;
  logic          vid_valid_q, vid_valid_d;
  logic          vid_late_q, vid_late_d;
  logic          vid_pend_q, vid_pend_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic          cpu_busy_q, cpu_busy_d;
  logic          cpu_done_q, cpu_done_d;
  logic [AW-1:0] a1_q, a1_d;
  logic [AW-1:0] a2_q, a2_d;
  logic          c_we_q, c_we_d;
  logic [AW-1:0] c_addr_q, c_addr_d;
  logic [7:0]    c_din_q, c_din_d;

  // Video word addresses are 16-bit aligned; their byte bit carries no information.
  logic unused_addr_bits;
  assign unused_addr_bits = a1_q[0] ^ a2_q[0];

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_din_d   = mem_din_q;
    vid_dout1_d = vid_dout1_q;
    vid_dout2_d = vid_dout2_q;
    vid_valid_d = 1'b0;
    vid_late_d  = vid_late_q;
    vid_pend_d  = vid_pend_q;
    cpu_dout_d  = cpu_dout_q;
    cpu_busy_d  = cpu_busy_q;
    cpu_done_d  = 1'b0;
    a1_d        = a1_q;
    a2_d        = a2_q;
    c_we_d      = c_we_q;
    c_addr_d    = c_addr_q;
    c_din_d     = c_din_q;

    case (state_q)
      S_IDLE: begin
        if (vid_pend_q) begin
          state_d    = S_V1;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = a1_q[AW-1:1];
          mem_be_d   = 2'b11;
        end else if (cpu_busy_q) begin
          state_d    = S_CPU;
          mem_req_d  = 1'b1;
          mem_we_d   = c_we_q;
          mem_addr_d = c_addr_q[AW-1:1];
          mem_be_d   = cpu_be(c_we_q, c_addr_q[0]);
          mem_din_d  = {c_din_q, c_din_q};
        end
      end
      S_V1: begin
        if (mem_ack) begin
          vid_dout1_d = mem_dout;
          mem_req_d   = 1'b0;
          state_d     = S_V2;
        end
      end
      S_V2: begin
        // First V2 cycle is the mandatory idle gap after the V1 ack; the second word issues after it.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = a2_q[AW-1:1];
          mem_be_d   = 2'b11;
        end else if (mem_ack) begin
          vid_dout2_d = mem_dout;
          vid_valid_d = 1'b1;
          vid_pend_d  = 1'b0;
          mem_req_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_CPU: begin
        if (mem_ack) begin
          cpu_dout_d = byte_sel(mem_dout, c_addr_q[0]);
          cpu_done_d = 1'b1;
          cpu_busy_d = 1'b0;
          mem_req_d  = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new video request always wins over the pending-flag clear of a completing pair.
    if (vid_req) begin
      a1_d       = vid_addr1;
      a2_d       = vid_addr2;
      vid_pend_d = 1'b1;
      if (vid_pend_q) vid_late_d = 1'b1;
    end
    if (cpu_req && !cpu_busy_q) begin
      c_we_d     = cpu_we;
      c_addr_d   = cpu_addr;
      c_din_d    = cpu_din;
      cpu_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 2'b00;
      mem_din_q   <= '0;
      vid_dout1_q <= '0;
      vid_dout2_q <= '0;
      vid_valid_q <= 1'b0;
      vid_late_q  <= 1'b0;
      vid_pend_q  <= 1'b0;
      cpu_dout_q  <= '0;
      cpu_busy_q  <= 1'b0;
      cpu_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_din_q   <= mem_din_d;
      vid_dout1_q <= vid_dout1_d;
      vid_dout2_q <= vid_dout2_d;
      vid_valid_q <= vid_valid_d;
      vid_late_q  <= vid_late_d;
      vid_pend_q  <= vid_pend_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_busy_q  <= cpu_busy_d;
      cpu_done_q  <= cpu_done_d;
    end
  end

  // Request latches are qualified by the pending flags, so they need no reset.
  always_ff @(posedge clk_sys) begin
    a1_q     <= a1_d;
    a2_q     <= a2_d;
    c_we_q   <= c_we_d;
    c_addr_q <= c_addr_d;
    c_din_q  <= c_din_d;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_din   = mem_din_q;
  assign vid_dout1 = vid_dout1_q;
  assign vid_dout2 = vid_dout2_q;
  assign vid_valid = vid_valid_q;
  assign vid_late  = vid_late_q;
  assign cpu_dout  = cpu_dout_q;
  assign cpu_busy  = cpu_busy_q;
  assign cpu_done  = cpu_done_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: tasks queue expected memory accesses and results,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_vram_arbiter;
  localparam int AW = 19;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_addr1, vid_addr2;
  logic [DW-1:0] vid_dout1, vid_dout2;
  logic          vid_valid, vid_late;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din, cpu_dout;
  logic          cpu_busy, cpu_done;
  logic          mem_req, mem_we;
  logic [AW-2:0] mem_addr;
  logic [1:0]    mem_be;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic          mem_ack;
  logic          ack_m = 1'b0;
  logic          ack_stray = 1'b0;

  assign mem_ack = ack_m | ack_stray;

  vram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_sys(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr1(vid_addr1), .vid_addr2(vid_addr2),
    .vid_dout1(vid_dout1), .vid_dout2(vid_dout2), .vid_valid(vid_valid), .vid_late(vid_late),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-2:0] addr; logic we; logic [1:0] be; logic [15:0] din; } mem_t;
  typedef struct { logic [15:0] d1; logic [15:0] d2; } vid_t;
  typedef struct { logic rd; logic [7:0] b; } cpu_t;

  mem_t        mem_exp[$];
  vid_t        vid_exp[$];
  cpu_t        cpu_exp[$];
  logic [15:0] rdq[$];

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  int cnt = 0;
  int cyc = 0;
  int vid_t_last = -1;
  int cpu_t_last = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory controller model: acks ack_delay cycles after the request is seen.
  always @(posedge clk) begin
    if (reset) begin
      ack_m <= 1'b0;
      cnt   <= 0;
    end else if (ack_m) begin
      ack_m <= 1'b0;
      cnt   <= 0;
    end else if (mem_req) begin
      if (cnt >= ack_delay) begin
        ack_m <= 1'b1;
        if (rdq.size() > 0) begin
          mem_dout <= rdq[0];
          rdq.delete(0);
        end else begin
          mem_dout <= 16'h0000;
        end
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  logic          prev_req = 1'b0;
  logic          prev_ack = 1'b0;
  logic [AW-2:0] cur_addr;
  logic [18:0]   cur_ctl;
  mem_t          me;
  vid_t          ve;
  cpu_t          ce;

  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (prev_ack) begin
        checks++;
        if (mem_req !== 1'b0) begin
          errors++;
          $display("FAIL mem_req_gap: mem_req=%b the cycle after ack, required 0", mem_req);
        end
      end
      if (mem_req && !prev_req) begin
        checks++;
        cur_addr = mem_addr;
        cur_ctl  = {mem_we, mem_be, mem_din};
        if (mem_exp.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected: request addr=%h we=%b, required none", mem_addr, mem_we);
        end else begin
          me = mem_exp.pop_front();
          if (mem_addr !== me.addr || mem_we !== me.we || mem_be !== me.be ||
              (me.we && mem_din !== me.din)) begin
            errors++;
            $display("FAIL mem_access: got addr=%h we=%b be=%b din=%h, required addr=%h we=%b be=%b din=%h",
                     mem_addr, mem_we, mem_be, mem_din, me.addr, me.we, me.be, me.din);
          end
        end
      end else if (mem_req && prev_req) begin
        checks++;
        if ({mem_addr, mem_we, mem_be, mem_din} !== {cur_addr, cur_ctl}) begin
          errors++;
          $display("FAIL mem_stable: addr=%h ctl=%h changed, required addr=%h ctl=%h",
                   mem_addr, {mem_we, mem_be, mem_din}, cur_addr, cur_ctl);
        end
      end
      if (vid_valid) begin
        checks++;
        vid_t_last = cyc;
        if (vid_exp.size() == 0) begin
          errors++;
          $display("FAIL vid_unexpected: vid_valid with dout1=%h dout2=%h, required none", vid_dout1, vid_dout2);
        end else begin
          ve = vid_exp.pop_front();
          if (vid_dout1 !== ve.d1 || vid_dout2 !== ve.d2) begin
            errors++;
            $display("FAIL vid_data: got %h/%h, required %h/%h", vid_dout1, vid_dout2, ve.d1, ve.d2);
          end
        end
      end
      if (cpu_done) begin
        checks++;
        cpu_t_last = cyc;
        if (cpu_exp.size() == 0) begin
          errors++;
          $display("FAIL cpu_unexpected: cpu_done with dout=%h, required none", cpu_dout);
        end else begin
          ce = cpu_exp.pop_front();
          if (ce.rd && cpu_dout !== ce.b) begin
            errors++;
            $display("FAIL cpu_rdata: got %h, required %h", cpu_dout, ce.b);
          end
        end
      end
      prev_req = mem_req;
      prev_ack = mem_ack;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_be, vid_valid, vid_late, cpu_busy, cpu_done} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctl: got %b, required 00000000",
               {mem_req, mem_we, mem_be, vid_valid, vid_late, cpu_busy, cpu_done});
    end
    checks++;
    if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h, required 0", mem_addr); end
    checks++;
    if (mem_din !== '0) begin errors++; $display("FAIL reset_din: got %h, required 0", mem_din); end
    checks++;
    if (vid_dout1 !== '0 || vid_dout2 !== '0) begin
      errors++; $display("FAIL reset_vdout: got %h/%h, required 0/0", vid_dout1, vid_dout2);
    end
    checks++;
    if (cpu_dout !== '0) begin errors++; $display("FAIL reset_cdout: got %h, required 0", cpu_dout); end
    reset = 1'b0;
  endtask

  task automatic test_video();
    int lat;
    rdq.push_back(16'h1234);
    rdq.push_back(16'hABCD);
    mem_exp.push_back('{addr: 18'h00020, we: 1'b0, be: 2'b11, din: 16'h0});
    mem_exp.push_back('{addr: 18'h03020, we: 1'b0, be: 2'b11, din: 16'h0});
    vid_exp.push_back('{d1: 16'h1234, d2: 16'hABCD});
    vid_addr1 = 19'h00040;
    vid_addr2 = 19'h06040;
    vid_req   = 1'b1;
    @(negedge clk);
    vid_req = 1'b0;
    lat = 1;
    while (!vid_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL vid_latency: got %0d cycles, required 7", lat); end
    @(negedge clk);
    checks++;
    if (vid_valid !== 1'b0) begin errors++; $display("FAIL vid_pulse: vid_valid=%b, required 0", vid_valid); end
    checks++;
    if (vid_late !== 1'b0) begin errors++; $display("FAIL vid_late_idle: got %b, required 0", vid_late); end
  endtask

  task automatic test_cpu_write();
    int n;
    int extra;
    rdq.push_back(16'h0000);
    mem_exp.push_back('{addr: 18'h00080, we: 1'b1, be: 2'b10, din: 16'h5A5A});
    cpu_exp.push_back('{rd: 1'b0, b: 8'h00});
    cpu_we = 1'b1; cpu_addr = 19'h00101; cpu_din = 8'h5A; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    n = 1;
    while (!cpu_done && n < 40) begin
      checks++;
      if (cpu_busy !== 1'b1) begin errors++; $display("FAIL cpu_busy: cycle %0d busy=%b, required 1", n, cpu_busy); end
      // A request while busy must be ignored: different address and data.
      cpu_req = (n == 2);
      if (n == 2) begin cpu_addr = 19'h003FF; cpu_din = 8'h11; cpu_we = 1'b0; end
      @(negedge clk);
      n++;
    end
    cpu_req = 1'b0;
    checks++;
    if (cpu_done !== 1'b1) begin errors++; $display("FAIL cpu_wr_timeout: cpu_done=%b, required 1", cpu_done); end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_done || cpu_busy) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL cpu_wr_single: %0d cycles of done/busy after completion, required 0", extra); end
  endtask

  task automatic test_cpu_read(input logic [AW-1:0] addr, input logic [15:0] word, input logic [7:0] exp_b);
    int n;
    rdq.push_back(word);
    mem_exp.push_back('{addr: addr[AW-1:1], we: 1'b0, be: 2'b11, din: 16'h0});
    cpu_exp.push_back('{rd: 1'b1, b: exp_b});
    cpu_we = 1'b0; cpu_addr = addr; cpu_din = 8'h00; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    n = 1;
    while (!cpu_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cpu_done !== 1'b1) begin errors++; $display("FAIL cpu_rd_timeout: cpu_done=%b, required 1", cpu_done); end
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_dout !== exp_b) begin errors++; $display("FAIL cpu_rd_hold: got %h, required %h", cpu_dout, exp_b); end
  endtask

  task automatic test_simultaneous();
    int n;
    rdq.push_back(16'h1111);
    rdq.push_back(16'h2222);
    rdq.push_back(16'hC0DE);
    mem_exp.push_back('{addr: 18'h00100, we: 1'b0, be: 2'b11, din: 16'h0});
    mem_exp.push_back('{addr: 18'h00201, we: 1'b0, be: 2'b11, din: 16'h0});
    mem_exp.push_back('{addr: 18'h00003, we: 1'b0, be: 2'b11, din: 16'h0});
    vid_exp.push_back('{d1: 16'h1111, d2: 16'h2222});
    cpu_exp.push_back('{rd: 1'b1, b: 8'hC0});
    vid_t_last = -1;
    cpu_t_last = -1;
    vid_addr1 = 19'h00200; vid_addr2 = 19'h00403; vid_req = 1'b1;
    cpu_we = 1'b0; cpu_addr = 19'h00007; cpu_req = 1'b1;
    @(negedge clk);
    vid_req = 1'b0;
    cpu_req = 1'b0;
    n = 1;
    while (!cpu_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (vid_t_last < 0 || cpu_t_last <= vid_t_last) begin
      errors++;
      $display("FAIL sim_order: vid_valid at %0d, cpu_done at %0d, required video first", vid_t_last, cpu_t_last);
    end
    checks++;
    if (vid_late !== 1'b0) begin errors++; $display("FAIL sim_late: got %b, required 0", vid_late); end
  endtask

  task automatic test_late();
    int n;
    ack_delay = 10;
    rdq.push_back(16'h7777);
    rdq.push_back(16'h8888);
    mem_exp.push_back('{addr: 18'h00800, we: 1'b0, be: 2'b11, din: 16'h0});
    mem_exp.push_back('{addr: 18'h02000, we: 1'b0, be: 2'b11, din: 16'h0});
    vid_exp.push_back('{d1: 16'h7777, d2: 16'h8888});
    vid_addr1 = 19'h01000; vid_addr2 = 19'h02000; vid_req = 1'b1;
    @(negedge clk);
    vid_req = 1'b0;
    repeat (3) @(negedge clk);
    vid_addr1 = 19'h03000; vid_addr2 = 19'h04000; vid_req = 1'b1;
    @(negedge clk);
    vid_req = 1'b0;
    checks++;
    if (vid_late !== 1'b1) begin errors++; $display("FAIL late_set: got %b, required 1", vid_late); end
    n = 0;
    while (!vid_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (vid_valid !== 1'b1) begin errors++; $display("FAIL late_timeout: vid_valid=%b, required 1", vid_valid); end
    ack_delay = 0;
    repeat (10) @(negedge clk);
    checks++;
    if (vid_late !== 1'b1) begin errors++; $display("FAIL late_sticky: got %b, required 1", vid_late); end
  endtask

  task automatic test_reset_mid();
    int n;
    int bad;
    ack_delay = 10;
    rdq.delete();
    rdq.push_back(16'h5555);
    mem_exp.push_back('{addr: 18'h00008, we: 1'b0, be: 2'b11, din: 16'h0});
    mem_exp.push_back('{addr: 18'h00010, we: 1'b0, be: 2'b11, din: 16'h0});
    vid_addr1 = 19'h00010; vid_addr2 = 19'h00020; vid_req = 1'b1;
    cpu_we = 1'b1; cpu_addr = 19'h00050; cpu_din = 8'h77; cpu_req = 1'b1;
    @(negedge clk);
    vid_req = 1'b0;
    cpu_req = 1'b0;
    n = 1;
    while (!(mem_req && mem_addr == 18'h00010) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(mem_req === 1'b1 && cpu_busy === 1'b1)) begin
      errors++;
      $display("FAIL rst_mid_setup: mem_req=%b busy=%b, required 1/1 in V2", mem_req, cpu_busy);
    end
    reset = 1'b1;
    @(negedge clk);
    mem_exp.delete();
    vid_exp.delete();
    cpu_exp.delete();
    rdq.delete();
    checks++;
    if ({mem_req, vid_valid, cpu_busy, cpu_done, vid_late} !== 5'b00000) begin
      errors++;
      $display("FAIL rst_mid: req/valid/busy/done/late=%b, required 00000",
               {mem_req, vid_valid, cpu_busy, cpu_done, vid_late});
    end
    reset = 1'b0;
    ack_delay = 0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_req || vid_valid || cpu_done) bad++;
    end
    ack_stray = 1'b1;
    @(negedge clk);
    ack_stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (mem_req || vid_valid || cpu_done || cpu_busy) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rst_idle: %0d active cycles after reset, required 0", bad); end
  endtask

  initial begin
    reset = 1'b1;
    vid_req = 1'b0; vid_addr1 = '0; vid_addr2 = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    @(negedge clk);
    test_reset();
    test_video();
    test_cpu_write();
    test_cpu_read(19'h00100, 16'hBEEF, 8'hEF);
    test_cpu_read(19'h00101, 16'hBEEF, 8'hBE);
    test_simultaneous();
    test_late();
    test_reset_mid();
    test_video();
    repeat (5) @(negedge clk);
    checks++;
    if (mem_exp.size() != 0 || vid_exp.size() != 0 || cpu_exp.size() != 0) begin
      errors++;
      $display("FAIL leftover: mem=%0d vid=%0d cpu=%0d expected items outstanding, required 0/0/0",
               mem_exp.size(), vid_exp.size(), cpu_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
